// File: rtl/demux8bit_8channel_buf_if.sv
// Byte-stream input and eight-channel output bundle for the 8-channel demux.
// Producer and consumers use the master side; the demux uses the slave side.
interface demux8bit_8channel_buf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic [WIDTH-1:0] out5;
  logic [WIDTH-1:0] out6;
  logic [WIDTH-1:0] out7;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
  );
endinterface

// File: rtl/demux8bit_8channel_buf.sv
// 8-bit 8-channel demultiplexer with one holding register per channel.
// Optional accept counter enabled by defining DEMUX8_ACCEPT_CNT_EN.
//
// state | meaning
// EMPTY | channel holds no unconsumed data, out_valid[i] = 0
// FULL  | channel holds data for its consumer, out_valid[i] = 1
module demux8bit_8channel_buf #(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  demux8bit_8channel_buf_if.slave         bus
`ifdef DEMUX8_ACCEPT_CNT_EN
  ,
  output logic [15:0]                     accept_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state [8];
  logic [WIDTH-1:0] data_q [8];
  logic             accept;

  // Readiness looks only at the addressed channel, so a stalled channel
  // never blocks traffic headed elsewhere.
  assign bus.in_ready = !rst && ((state[bus.in_sel] == EMPTY) || bus.out_ready[bus.in_sel]);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        state[i]  <= EMPTY;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept && (bus.in_sel == 3'(i))) begin
          state[i]  <= FULL;
          data_q[i] <= bus.in_data;
        end else if ((state[i] == FULL) && bus.out_ready[i]) begin
          state[i] <= EMPTY;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    for (int i = 0; i < 8; i++) begin
      bus.out_valid[i] = (state[i] == FULL);
    end
  end

  assign bus.out0 = data_q[0];
  assign bus.out1 = data_q[1];
  assign bus.out2 = data_q[2];
  assign bus.out3 = data_q[3];
  assign bus.out4 = data_q[4];
  assign bus.out5 = data_q[5];
  assign bus.out6 = data_q[6];
  assign bus.out7 = data_q[7];

`ifdef DEMUX8_ACCEPT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux8bit_8channel_buf.sv
// Scoreboard bench for demux8bit_8channel_buf: accepted bytes are queued per
// channel and a negedge monitor checks every drained byte against its queue.
module tb_demux8bit_8channel_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux8bit_8channel_buf_if #(.WIDTH(8)) bus ();

`ifdef DEMUX8_ACCEPT_CNT_EN
  logic [15:0] accept_cnt;
`endif

  demux8bit_8channel_buf #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DEMUX8_ACCEPT_CNT_EN
    ,
    .accept_cnt (accept_cnt)
`endif
  );

  logic [7:0]  outs [8];
  logic [7:0]  exp_q [8][$];
  logic [15:0] exp_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  assign outs[0] = bus.out0;
  assign outs[1] = bus.out1;
  assign outs[2] = bus.out2;
  assign outs[3] = bus.out3;
  assign outs[4] = bus.out4;
  assign outs[5] = bus.out5;
  assign outs[6] = bus.out6;
  assign outs[7] = bus.out7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a byte leaves channel i at the next edge when valid and ready.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected drain ch%0d", i), 32'(outs[i]), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("drain ch%0d", i), 32'(outs[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [7:0] d, output int waits);
    bit done;
    done = 0;
    waits = 0;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q[sel].push_back(d);
        exp_cnt = exp_cnt + 16'd1;
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          chk("send timeout", 32'(waits), 32'd0);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    exp_cnt = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("in_ready in reset", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'h00);
    for (int i = 0; i < 8; i++) chk($sformatf("%s out%0d", tag, i), 32'(outs[i]), 32'h00);
`ifdef DEMUX8_ACCEPT_CNT_EN
    chk({tag, " accept_cnt"}, 32'(accept_cnt), 32'h0);
`endif
  endtask

  initial begin
    int w;
    int t0;
    int pend;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 8'h00;
    exp_cnt       = '0;
    @(posedge clk);
    #1;

    // Reset then idle
    do_reset(2);
    @(negedge clk);
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // Single route
    send(3'd5, 8'hA5, w);
    @(negedge clk);
    chk("route out_valid", 32'(bus.out_valid), 32'h20);
    chk("route out5", 32'(bus.out5), 32'hA5);
    chk("route out0 unchanged", 32'(bus.out0), 32'h00);
    @(posedge clk);
    #1;

    // Backpressure on the stalled channel
    bus.in_sel = 3'd5;
    bus.in_data = 8'h3C;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp in_ready 2", 32'(bus.in_ready), 32'd0);
    chk("bp out5 held", 32'(bus.out5), 32'hA5);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    // Non-blocking: other channels still flow
    send(3'd2, 8'h11, w);
    chk("nonblock waits", 32'(w), 32'd0);
    @(negedge clk);
    chk("nonblock out_valid", 32'(bus.out_valid), 32'h24);
    chk("nonblock out2", 32'(bus.out2), 32'h11);
    @(posedge clk);
    #1;

    // Release channel 5 for one cycle: drain and reload together
    bus.out_ready = 8'h20;
    send(3'd5, 8'h3C, w);
    bus.out_ready = 8'h00;
    chk("release waits", 32'(w), 32'd0);
    @(negedge clk);
    chk("release out5", 32'(bus.out5), 32'h3C);
    chk("release out_valid", 32'(bus.out_valid), 32'h24);
    @(posedge clk);
    #1;

    // Streaming from a clean start
    do_reset(1);
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(3'(i), 8'h10 + 8'(i), w);
    chk("stream first pass cycles", 32'(cyc - t0), 32'd8);
    @(negedge clk);
    chk("stream out_valid", 32'(bus.out_valid), 32'hFF);
    for (int i = 0; i < 8; i++) chk($sformatf("stream out%0d", i), 32'(outs[i]), 32'h10 + 32'(i));
`ifdef DEMUX8_ACCEPT_CNT_EN
    chk("stream accept_cnt", 32'(accept_cnt), 32'd8);
`endif
    @(posedge clk);
    #1;
    bus.out_ready = 8'hFF;
    t0 = cyc;
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 8; i++) send(3'(i), 8'h10 + 8'(i), w);
    chk("stream full-rate cycles", 32'(cyc - t0), 32'd64);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 8'h00;
    @(negedge clk);
    chk("stream drained", 32'(bus.out_valid), 32'h00);
    @(posedge clk);
    #1;

    // Reset mid-stream with three channels full
    send(3'd1, 8'h21, w);
    send(3'd4, 8'h44, w);
    send(3'd6, 8'h66, w);
    @(negedge clk);
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'h52);
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    check_all_zero("mid reset");
    @(posedge clk);
    #1;

    // Same-channel drain and load in one cycle
    send(3'd3, 8'h77, w);
    bus.out_ready = 8'h08;
    send(3'd3, 8'h88, w);
    bus.out_ready = 8'h00;
    chk("drain+load waits", 32'(w), 32'd0);
    @(negedge clk);
    chk("drain+load out_valid", 32'(bus.out_valid), 32'h08);
    chk("drain+load out3", 32'(bus.out3), 32'h88);
    @(posedge clk);
    #1;

`ifdef DEMUX8_ACCEPT_CNT_EN
    // Counter wrap: stream until the counter sits at FFFF, then one more
    bus.out_ready = 8'hFF;
    while (exp_cnt != 16'hFFFF) begin
      send(exp_cnt[2:0], exp_cnt[7:0], w);
      if (w != 0) chk("wrap stream stall", 32'(w), 32'd0);
    end
    @(negedge clk);
    chk("accept_cnt at max", 32'(accept_cnt), 32'hFFFF);
    @(posedge clk);
    #1;
    send(3'd0, 8'h5A, w);
    @(negedge clk);
    chk("accept_cnt wrapped", 32'(accept_cnt), 32'h0000);
    @(posedge clk);
    #1;
`endif

    // Drain everything and confirm nothing is left or lost
    bus.out_ready = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final out_valid", 32'(bus.out_valid), 32'h00);
    pend = 0;
    for (int i = 0; i < 8; i++) pend += exp_q[i].size();
    chk("final pending", 32'(pend), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
